// File: rtl/s1_tx_pkg.sv
// Shared types and constants for the S1 serial transmitter.
// Frame geometry defaults match the RB1 bank (3-bit address, 18-bit data).
package s1_tx_pkg;

    localparam int S1_ADDR_W = 3;
    localparam int S1_DATA_W = 18;
    localparam int FRAME_W   = S1_ADDR_W + S1_DATA_W;

    // Width of the inter-frame idle counter; bounds GAP to 2**GAP_CNT_W.
    localparam int GAP_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s1_piso.sv
// Parallel-load, MSB-first shift register holding one address+data frame.
// Load has priority over shift; shifting fills from the LSB with zeros.
module s1_piso
    import s1_tx_pkg::*;
#(
    parameter int W = FRAME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[W-2:0], 1'b0};
        end
    end

    assign dout = sreg[W-1];

endmodule

// File: rtl/s1_serial_tx.sv
// Reads NUM_WORDS words from RB1 and sends each as an address+data frame on sen/sd.
// Every output is registered; the FSM, word index and bit counter live here.
module s1_serial_tx
    import s1_tx_pkg::*;
#(
    parameter int ADDR_W    = S1_ADDR_W,
    parameter int DATA_W    = S1_DATA_W,
    parameter int NUM_WORDS = 8,
    parameter int GAP       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              RB1_RW,
    output logic [ADDR_W-1:0] RB1_A,
    input  logic [DATA_W-1:0] RB1_Q,
    output logic              sen,
    output logic              sd,
    output logic              S1_done
);

    localparam int FW    = ADDR_W + DATA_W;
    localparam int BIT_W = cnt_w(FW);

    // The last word is found by compare, so NUM_WORDS = 2**ADDR_W never relies on wrap.
    localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [BIT_W-1:0]     BIT_TOP  = BIT_W'(FW - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_TOP  = GAP_CNT_W'(GAP - 1);

    state_t               state;
    logic [ADDR_W-1:0]    word_idx;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;

    logic piso_load;
    logic piso_shift;
    logic piso_dout;

    assign piso_load  = (state == S_LOAD);
    assign piso_shift = (state == S_SEND);

    s1_piso #(
        .W (FW)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .din   ({RB1_A, RB1_Q}),
        .dout  (piso_dout)
    );

    // NOTE: all state and output registers use non-blocking assignments so every
    // update in this block sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_idx <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            RB1_RW   <= 1'b1;
            RB1_A    <= '0;
            sen      <= 1'b1;
            sd       <= 1'b0;
            S1_done  <= 1'b0;
        end else begin
            // Idle line by default; only SEND pulls sen low.
            RB1_RW <= 1'b1;
            sen    <= 1'b1;
            sd     <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_READ;
                        word_idx <= '0;
                        RB1_A    <= '0;
                        S1_done  <= 1'b0;
                    end
                end

                // RB1_A is already on the bus; RB1_Q becomes valid for LOAD.
                S_READ: begin
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    state   <= S_SEND;
                    bit_cnt <= BIT_TOP;
                end

                S_SEND: begin
                    sen <= 1'b0;
                    sd  <= piso_dout;
                    if (bit_cnt == '0) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_TOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (word_idx == LAST_IDX) begin
                            state   <= S_DONE;
                            S1_done <= 1'b1;
                        end else begin
                            state    <= S_READ;
                            word_idx <= word_idx + 1'b1;
                            RB1_A    <= word_idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s1_serial_tx.sv
// Directed bench for s1_serial_tx: RB1 model, frame decoder feeding an RB2 model,
// and table-driven frame checks across normal, restart, held-start and reset runs.
module tb_s1_serial_tx;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 18;
    localparam int NUM_WORDS = 8;
    localparam int GAP       = 1;
    localparam int FW        = ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              RB1_RW;
    logic [ADDR_W-1:0] RB1_A;
    logic [DATA_W-1:0] RB1_Q;
    logic              sen;
    logic              sd;
    logic              S1_done;

    logic [DATA_W-1:0] rb1 [NUM_WORDS];
    logic [DATA_W-1:0] rb2 [NUM_WORDS];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        int          nbits;
        logic [FW-1:0] value;
        int          pre_high;
    } rx_t;

    exp_t exp_tab [NUM_WORDS];
    rx_t  frames [$];

    int checks   = 0;
    int failures = 0;

    // Monitor-owned state (written only by the decoder process).
    int          sd_bad     = 0;
    int          rw_bad     = 0;
    int          low_cycles = 0;
    int          nbits      = 0;
    int          high_run   = 0;
    int          cur_pre    = 0;
    logic [FW-1:0] sh       = '0;

    s1_serial_tx #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .GAP       (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_Q   (RB1_Q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RB1: synchronous read, data valid one cycle after the address.
    always @(posedge clk) RB1_Q <= rb1[RB1_A];

    // Serial decoder acting as the S2 receive path; writes decoded words into rb2.
    always @(negedge clk) begin
        rx_t r;
        if (RB1_RW !== 1'b1) rw_bad++;
        if (!rst) begin
            nbits    = 0;
            high_run = 0;
        end else if (sen === 1'b1) begin
            if (sd !== 1'b0) sd_bad++;
            if (nbits != 0) begin
                r.nbits    = nbits;
                r.value    = sh;
                r.pre_high = cur_pre;
                frames.push_back(r);
                if (nbits == FW) rb2[sh[FW-1:DATA_W]] = sh[DATA_W-1:0];
                nbits = 0;
            end
            high_run++;
        end else begin
            if (nbits == 0) begin
                cur_pre  = high_run;
                high_run = 0;
            end
            low_cycles++;
            sh = {sh[FW-2:0], sd};
            nbits++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_run(input int base, input string tag);
        int got;
        got = frames.size() - base;
        check({tag, "_frames"}, 64'(got), 64'(NUM_WORDS));
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (base + k < frames.size()) begin
                check($sformatf("%s_w%0d_bits", tag, k), 64'(frames[base+k].nbits), 64'(FW));
                check($sformatf("%s_w%0d_frame", tag, k), 64'(frames[base+k].value),
                      64'({exp_tab[k].addr, exp_tab[k].data}));
                if (k > 0)
                    check($sformatf("%s_w%0d_gap", tag, k), 64'(frames[base+k].pre_high),
                          64'(GAP + 2));
            end
        end
    endtask

    // Counts negedges until S1_done is seen; n starts at the caller's current count.
    task automatic wait_done(input int limit, inout int n, output bit ok);
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (S1_done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int  base;
        int  n;
        bit  ok;
        int  low0;
        int  fr0;

        exp_tab[0] = '{3'd0, 18'h2A5A0};
        exp_tab[1] = '{3'd1, 18'h2A5A1};
        exp_tab[2] = '{3'd2, 18'h2A5A2};
        exp_tab[3] = '{3'd3, 18'h2A5A3};
        exp_tab[4] = '{3'd4, 18'h2A5A4};
        exp_tab[5] = '{3'd5, 18'h2A5A5};
        exp_tab[6] = '{3'd6, 18'h2A5A6};
        exp_tab[7] = '{3'd7, 18'h2A5A7};
        for (int k = 0; k < NUM_WORDS; k++) rb1[k] = 18'h2A5A0 + 18'(k);

        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(S1_done), 64'(0));
        check("rst_rw",   64'(RB1_RW),  64'(1));
        check("rst_addr", 64'(RB1_A),   64'(0));
        check("rst_sen",  64'(sen),     64'(1));
        check("rst_sd",   64'(sd),      64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sen", 64'(sen), 64'(1));

        // Basic run with latency: n counts negedges after the start edge E.
        base = frames.size();
        pulse_start();
        @(negedge clk) check("lat_after_e0_sen", 64'(sen), 64'(1));
        @(negedge clk) check("lat_after_e1_sen", 64'(sen), 64'(1));
        @(negedge clk) check("lat_after_e2_sen", 64'(sen), 64'(1));
        @(negedge clk) begin
            check("lat_after_e3_sen", 64'(sen), 64'(0));
            check("lat_after_e3_sd",  64'(sd),  64'(0));
        end
        n = 4;
        wait_done(600, n, ok);
        check("run1_done_seen", 64'(ok), 64'(1));
        check("run1_done_cycle", 64'(n), 64'(193));
        #1;
        check_run(base, "run1");
        for (int k = 0; k < NUM_WORDS; k++)
            check($sformatf("loop_w%0d", k), 64'(rb2[k]), 64'(rb1[k]));
        repeat (5) @(negedge clk);
        check("run1_done_sticky", 64'(S1_done), 64'(1));
        check("run1_no_extra", 64'(frames.size() - base), 64'(NUM_WORDS));

        // Restart from DONE, with start pulses landing inside SEND.
        base = frames.size();
        pulse_start();
        @(negedge clk) check("restart_done_drop", 64'(S1_done), 64'(0));
        n  = 1;
        ok = 1'b0;
        while (n < 600 && !ok) begin
            @(negedge clk);
            n++;
            start = (n == 30 || n == 55 || n == 100);
            if (S1_done === 1'b1) ok = 1'b1;
        end
        start = 1'b0;
        check("run2_done_seen", 64'(ok), 64'(1));
        check("run2_done_cycle", 64'(n), 64'(193));
        #1;
        check_run(base, "run2");

        // start held high for the whole run, dropped once done is observed.
        base = frames.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 0;
        wait_done(600, n, ok);
        start = 1'b0;
        check("run3_done_seen", 64'(ok), 64'(1));
        #1;
        check_run(base, "run3");
        repeat (10) @(negedge clk);
        check("run3_single_run", 64'(frames.size() - base), 64'(NUM_WORDS));
        check("run3_done_hold", 64'(S1_done), 64'(1));

        // Reset during bit 10 of word 4.
        base = frames.size();
        pulse_start();
        n = 0;
        repeat (110) begin
            @(negedge clk);
            n++;
        end
        check("mid_pre_sen", 64'(sen), 64'(0));
        check("mid_pre_frames", 64'(frames.size() - base), 64'(4));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sen",  64'(sen),     64'(1));
        check("mid_rst_sd",   64'(sd),      64'(0));
        check("mid_rst_addr", 64'(RB1_A),   64'(0));
        check("mid_rst_done", 64'(S1_done), 64'(0));
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        low0 = low_cycles;
        fr0  = frames.size();
        repeat (10) @(negedge clk);
        check("mid_quiet_low", 64'(low_cycles), 64'(low0));
        check("mid_quiet_frames", 64'(frames.size()), 64'(fr0));
        check("mid_quiet_done", 64'(S1_done), 64'(0));

        base = frames.size();
        pulse_start();
        n = 0;
        wait_done(600, n, ok);
        check("run4_done_seen", 64'(ok), 64'(1));
        #1;
        check_run(base, "run4");

        check("sd_zero_when_idle", 64'(sd_bad), 64'(0));
        check("rw_always_read", 64'(rw_bad), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s1_serial_tx.md
Name: s1_serial_tx

Overview:
- Serial transmitter feeding the S2 receive path. Reads NUM_WORDS entries from register bank RB1 and sends each one as an address+data frame on the sen/sd serial link.
- Frame: sen low for ADDR_W+DATA_W consecutive cycles carrying the address MSB-first, then the data MSB-first; sen high between frames.
- Asserts S1_done once every word has been sent. Sits between RB1 and the S2 serial input.

Parameters:
- ADDR_W, 3, RB1 address width and number of address bits per frame
- DATA_W, 18, RB1 word width and number of data bits per frame
- NUM_WORDS, 8, number of words sent per run (at most 2**ADDR_W)
- GAP, 1, extra sen-high idle cycles after each frame (at least 1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  begins a run; sampled only in IDLE or DONE
- RB1_RW  out  1  RB1 read/write select; held 1 (read) at all times
- RB1_A  out  ADDR_W  RB1 read address
- RB1_Q  in  DATA_W  RB1 read data, valid one cycle after RB1_A is presented
- sen  out  1  serial enable; 0 = sd carries a valid frame bit
- sd  out  1  serial data bit
- S1_done  out  1  run complete

Behaviour:
- Reset (rst=0, any state, including mid-frame):
  - outputs go immediately to S1_done=0, RB1_RW=1, RB1_A=0, sen=1, sd=0
  - FSM goes to IDLE; word index and bit counter clear to 0
- All outputs are registered.
- States: IDLE, READ, LOAD, SEND, GAP, DONE.
- IDLE: sen=1. If start=1, next state is READ with word index 0.
- READ, one cycle:
  - RB1_A is driven to the word index; sen=1
  - word index k maps to RB1_A = k, so words go in ascending order 0..NUM_WORDS-1
- LOAD, one cycle: the shift register captures {RB1_A, RB1_Q} (ADDR_W+DATA_W bits); sen=1.
- SEND, ADDR_W+DATA_W cycles:
  - each cycle sen=0 and sd carries the current MSB, then the register shifts left
  - first sen=0 cycle carries addr[ADDR_W-1]; last carries data[0]
  - the bit counter counts down from ADDR_W+DATA_W-1 to 0
- GAP, GAP cycles: sen=1, sd=0. At the end:
  - if word index = NUM_WORDS-1, go to DONE
  - otherwise increment the word index and go to READ
- Inter-frame sen-high run is exactly GAP+2 cycles (GAP, READ and LOAD).
- DONE:
  - S1_done=1 (sticky), sen=1
  - start=1 clears S1_done and starts a new run at word 0 (enters READ)
- Latency: start=1 sampled at edge E puts the first sen=0 bit on the outputs after edge E+3. Per-word period is ADDR_W+DATA_W+GAP+2 cycles.
- start is ignored in READ, LOAD, SEND and GAP. Holding start high through the whole run does not restart the run.
- sd is 0 whenever sen=1. sen never goes low outside SEND.
- Word index and bit counter never wrap mid-run. The word index is ADDR_W bits wide, and NUM_WORDS = 2**ADDR_W is legal: the last word is detected by comparison, not by overflow.

Decomposition:
- Package s1_tx_pkg holds:
  - the state enum (IDLE, READ, LOAD, SEND, GAP, DONE)
  - localparam FRAME_W = ADDR_W+DATA_W
  - the GAP counter width
- Sub-module s1_piso: a parallel-load, MSB-first shift register.
  - ports: clk, rst, load, shift, din[FRAME_W-1:0], dout
- The top level holds the FSM, the word index, the bit counter and the output registers.

Test Plan:
- Basic run:
  - stimulus: RB1 preloaded with word k = 18'h2A5A0+k; single start pulse
  - required: 8 frames, each 21 sen=0 bits decoding to addr=k and data=18'h2A5A0+k, k = 0..7 in order
  - required: S1_done rises after the last GAP cycle
- Timing:
  - stimulus: start sampled at edge E
  - required: first sen=0 after edge E+3
  - required: every inter-frame sen-high run is exactly 3 cycles with GAP=1
  - required: sd=0 whenever sen=1
- Loopback:
  - stimulus: sen/sd connected to the S2 receiver
  - required: after both done flags are set, the RB2 contents equal RB1
- Reset mid-frame:
  - stimulus: rst=0 during bit 10 of word 4
  - required: sen=1, sd=0, RB1_A=0, S1_done=0 immediately, with no further sen=0 cycles
  - stimulus: after release, a new start
  - required: transmission restarts at word 0
- start held high:
  - stimulus: start held high from start of run to end
  - required: exactly one run of 8 frames
  - stimulus: start pulses during SEND
  - required: ignored, no frame corruption
- Restart from DONE:
  - stimulus: start=1 while S1_done=1
  - required: S1_done drops the next cycle and a full second run of 8 frames follows
